// File: rtl/lane_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lane_serializer : unpacks a (2**WAY)-lane parallel word into one lane per beat
// Rev 1.0
// ----------------------------------------------------------------------------
module lane_serializer #(
  parameter int WIRE = 3,
  parameter int WAY  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_in_valid,
  output logic                             o_in_ready,
  input  logic [(2**WAY)*(2**WIRE)-1:0]    i_in,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic [(2**WIRE)-1:0]             o_out,
  output logic [WAY-1:0]                   o_out_idx,
  output logic                             o_out_last
);

  localparam int LANE_W = 2**WIRE;
  localparam int NLANES = 2**WAY;
  localparam int WORD_W = NLANES * LANE_W;

  localparam logic [WAY-1:0] c_IDX_LAST = {WAY{1'b1}};

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [WAY-1:0]    r_idx;
  logic [WAY-1:0]    w_idx_next;
  logic [WORD_W-1:0] r_word;

  logic              w_load;
  logic              w_xfer;
  logic [LANE_W-1:0] w_lanes [NLANES];

  generate
    for (genvar k = 0; k < NLANES; k++) begin : g_lanes
      assign w_lanes[k] = r_word[k*LANE_W +: LANE_W];
    end
  endgenerate

  // State register plus the word/lane-counter datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (w_load) begin
        r_word <= i_in;
      end
    end
  end

  // A load on the last-beat transfer keeps SHIFT, giving bubble-free words
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (w_load) begin
      w_state_next = S_SHIFT;
      w_idx_next   = '0;
    end else if (w_xfer) begin
      w_idx_next = r_idx + WAY'(1);
      if (r_idx == c_IDX_LAST) begin
        w_state_next = S_IDLE;
      end
    end
  end

  always_comb begin
    o_out_valid = (r_state == S_SHIFT);
    o_out_last  = o_out_valid && (r_idx == c_IDX_LAST);
    o_out       = w_lanes[r_idx];
    o_out_idx   = r_idx;
    w_xfer      = o_out_valid && i_out_ready;
    o_in_ready  = (r_state == S_IDLE) || (w_xfer && o_out_last);
    w_load      = i_in_valid && o_in_ready;
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_serializer.sv
`default_nettype none
// tb_lane_serializer : directed checks of lane_serializer with WIRE=3, WAY=2
module tb_lane_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_in;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [7:0]  o_out;
  logic [1:0]  o_out_idx;
  logic        o_out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_serializer #(.WIRE(3), .WAY(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in        (i_in),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out       (o_out),
    .o_out_idx   (o_out_idx),
    .o_out_last  (o_out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    reset = 1'b1; i_in_valid = 1'b1; i_in = 32'hDEADBEEF; i_out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0; i_in_valid = 1'b0;
    #1;
    got = {o_out_valid, o_in_ready, o_out, o_out_last, o_out_idx[0]};
    checks++;
    if (got !== 12'b0_1_00000000_0_0 || o_out_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ready=%b out=%h last=%b idx=%0d want 0 1 00 0 0",
               o_out_valid, o_in_ready, o_out, o_out_last, o_out_idx);
    end
    tick(); #1;
    checks++;
    if (o_out_valid !== 1'b0 || o_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_no_load: got valid=%b out=%h want 0 00", o_out_valid, o_out);
    end
  endtask

  task automatic test_single();
    logic [7:0]  lanes [4] = '{8'd187, 8'd187, 8'd187, 8'd203};
    logic [11:0] exp_v;
    logic [11:0] got;
    i_in = 32'hCBBBBBBB; i_in_valid = 1'b1; i_out_ready = 1'b1;
    #1;
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b want 1", o_in_ready);
    end
    tick();
    i_in_valid = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      exp_v = {1'b1, lanes[b], 2'(b), 1'(b == 3)};
      got   = {o_out_valid, o_out, o_out_idx, o_out_last};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL single_beat%0d: got v/out/idx/last=%h want %h", b, got, exp_v);
      end
      tick(); #1;
    end
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_end: got valid=%b ready=%b want 0 1", o_out_valid, o_in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] got;
    logic [9:0] exp_v;
    i_in = 32'h04030201; i_in_valid = 1'b1; i_out_ready = 1'b1;
    tick();
    i_in = 32'h08070605;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        i_in_valid = 1'b0;
        #1;
      end
      exp_v = {1'b1, 8'(i + 1), 1'(i == 3 || i == 7)};
      got   = {o_out_valid, o_out, o_in_ready};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL b2b_beat%0d: got valid/out/in_ready=%h want %h", i, got, exp_v);
      end
      tick(); #1;
    end
    checks++;
    if (o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got valid=%b want 0", o_out_valid);
    end
  endtask

  task automatic test_backpressure();
    i_in = 32'h44332211; i_in_valid = 1'b1; i_out_ready = 1'b1;
    tick();
    i_in_valid = 1'b0;
    #1;
    checks++;
    if (o_out !== 8'h11 || o_out_idx !== 2'd0) begin
      errors++;
      $display("FAIL bp_lane0: got out=%h idx=%0d want 11 0", o_out, o_out_idx);
    end
    tick();
    i_out_ready = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (o_out !== 8'h22 || o_out_idx !== 2'd1 || o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: got out=%h idx=%0d valid=%b ready=%b want 22 1 1 0",
                 s, o_out, o_out_idx, o_out_valid, o_in_ready);
      end
      tick(); #1;
    end
    i_out_ready = 1'b1;
    #1;
    checks++;
    if (o_out !== 8'h22 || o_out_idx !== 2'd1) begin
      errors++;
      $display("FAIL bp_release: got out=%h idx=%0d want 22 1", o_out, o_out_idx);
    end
    tick(); #1;
    checks++;
    if (o_out !== 8'h33 || o_out_idx !== 2'd2 || o_out_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_lane2: got out=%h idx=%0d last=%b want 33 2 0", o_out, o_out_idx, o_out_last);
    end
    tick(); #1;
    checks++;
    if (o_out !== 8'h44 || o_out_idx !== 2'd3 || o_out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_lane3: got out=%h idx=%0d last=%b want 44 3 1", o_out, o_out_idx, o_out_last);
    end
    tick(); #1;
    checks++;
    if (o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got valid=%b want 0", o_out_valid);
    end
  endtask

  task automatic test_ignored_input();
    logic [7:0] lanes [4] = '{8'h21, 8'h43, 8'h65, 8'h87};
    i_in = 32'h87654321; i_in_valid = 1'b1; i_out_ready = 1'b1;
    tick();
    i_in = 32'hFFFFFFFF;
    #1;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        i_in_valid = 1'b0;
        #1;
      end
      checks++;
      if (o_out !== lanes[b] || o_out_valid !== 1'b1 || (b < 2 && o_in_ready !== 1'b0)) begin
        errors++;
        $display("FAIL ignore_beat%0d: got out=%h valid=%b ready=%b want %h 1",
                 b, o_out, o_out_valid, o_in_ready, lanes[b]);
      end
      tick(); #1;
    end
    checks++;
    if (o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_end: got valid=%b want 0", o_out_valid);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] lanes [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    i_in = 32'h55667788; i_in_valid = 1'b1; i_out_ready = 1'b1;
    tick();
    i_in_valid = 1'b0;
    tick(); tick();
    checks++;
    if (o_out_idx !== 2'd2 || o_out !== 8'h66) begin
      errors++;
      $display("FAIL midrst_pre: got idx=%0d out=%h want 2 66", o_out_idx, o_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: got valid=%b ready=%b want 0 1", o_out_valid, o_in_ready);
    end
    i_in = 32'h0D0C0B0A; i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (o_out !== lanes[b] || o_out_idx !== 2'(b) || o_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL midrst_beat%0d: got out=%h idx=%0d valid=%b want %h %0d 1",
                 b, o_out, o_out_idx, o_out_valid, lanes[b], b);
      end
      tick(); #1;
    end
  endtask

  initial begin
    reset = 1'b1; i_in_valid = 1'b0; i_in = '0; i_out_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_ignored_input();
    test_reset_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
